// File: rtl/uart_buffer_ctrl.sv
// uart_buffer_ctrl: circular FIFO controller that shares one genram port
// between the uart_rx writer and the uart_tx reader; writes win.
module uart_buffer_ctrl #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          rcv,
  input  logic [DW-1:0] rx_data,
  input  logic          tx_ready,
  output logic          tx_start,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rw,
  output logic [DW-1:0] ram_din,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          ovf
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    SEND,
    WAIT_BUSY
  } state_e;

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          is_full;
  logic          is_empty;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign is_full  = count_q[AW];
  assign is_empty = (count_q == '0);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pend_d   = pend_q;
    data_d   = data_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (pend_q && is_full) begin
          pend_d = 1'b0;
          ovf_d  = 1'b1;
        end else if (pend_q) begin
          state_d = WRITE;
        end else if (!is_empty && tx_ready) begin
          state_d = READ;
        end
      end
      WRITE: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = count_q + CNT_ONE;
        pend_d   = 1'b0;
        state_d  = IDLE;
      end
      READ: begin
        state_d = SEND;
      end
      SEND: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_q - CNT_ONE;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // a fresh byte overrides the WRITE-cycle clear of pend
    if (rcv) begin
      if (pend_q && (state_q != WRITE)) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = 1'b1;
        data_d = rx_data;
      end
    end

    if (clr) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pend_d   = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tx_start = (state_q == SEND) && !clr;
  assign ram_rw   = (state_q != WRITE);
  assign ram_addr = (state_q == WRITE) ? wr_ptr_q : rd_ptr_q;
  assign ram_din  = data_q;
  assign count    = count_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign ovf      = ovf_q;

endmodule
